// File: rtl/uart_tx_pkg.sv
// Shared UART definitions: frame constants, FSM state encoding and the
// default baud divisor formula reused by the receive path.
package uart_tx_pkg;

    localparam int DATA_BITS  = 8;
    localparam int OVERSAMPLE = 16;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } tx_state_t;

    // 16x tick period minus one for a given core clock (MHz) and baud rate
    function automatic logic [7:0] default_divisor(input int clk_mhz, input int baud);
        return 8'(clk_mhz * 62500 / baud - 1);
    endfunction

endpackage

// File: rtl/uart_tx_fifo.sv
// Synchronous byte FIFO with registered occupancy level.
// Latency: a push is visible at the head (and in level) one clock later.
// Backpressure: pushes while full are refused unless a pop happens in the same cycle.
module uart_tx_fifo #(
    parameter int AW = 4,
    parameter int W  = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          wr_en,
    input  logic [W-1:0]  wr_data,
    input  logic          rd_en,
    output logic [W-1:0]  rd_data,
    output logic          full,
    output logic          empty,
    output logic [AW:0]   level
);

    localparam logic [AW:0]   LVL_ONE = 1;
    localparam logic [AW-1:0] PTR_ONE = 1;

    logic [W-1:0]  mem [2**AW];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          push;
    logic          pop;

    assign full    = level[AW];
    assign empty   = (level == '0);
    assign pop     = rd_en & ~empty;
    // when full, the slot being popped is the one the push overwrites
    assign push    = wr_en & (~full | pop);
    assign rd_data = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_ONE;
            if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
            case ({push, pop})
                2'b10:   level <= level + LVL_ONE;
                2'b01:   level <= level - LVL_ONE;
                default: level <= level;
            endcase
        end
    end

endmodule

// File: rtl/uart_tx.sv
// UART transmitter: buffers bytes and serialises them 8N1/8N2, LSB first, on uart_txd.
// Latency: push into an empty FIFO drives the start bit 2 clocks later; back-to-back frames have no gap.
// Backpressure: tx_fifo_rdy drops when full; a push while full (without a pop) is dropped and sets sticky overrun.
module uart_tx
    import uart_tx_pkg::*;
#(
    parameter int FIFO_AW   = 4,
    parameter int STOP_BITS = 1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               tx_fifo_wr_en,
    input  logic [7:0]         tx_fifo_wr_data,
    input  logic [7:0]         baud_16x_in_cycles,
    input  logic               tx_overrun_clr,
    output logic               tx_fifo_rdy,
    output logic               tx_fifo_overrun,
    output logic [FIFO_AW:0]   tx_fifo_level,
    output logic               tx_busy,
    output logic               uart_txd
);

    localparam logic [4:0] LAST_TICK_BIT  = 5'(OVERSAMPLE - 1);
    localparam logic [4:0] LAST_TICK_STOP = 5'(OVERSAMPLE * STOP_BITS - 1);
    localparam logic [2:0] LAST_DATA_BIT  = 3'(DATA_BITS - 1);

    tx_state_t  state, state_nxt;
    logic [7:0] tick_cnt;
    logic       tick;
    logic [4:0] sub_cnt, sub_cnt_nxt;
    logic [2:0] bit_idx, bit_idx_nxt;
    logic [7:0] shift, shift_nxt;
    logic       bit_end;
    logic       txd_nxt;
    logic       pop;
    logic [7:0] fifo_dat;
    logic       fifo_full;
    logic       fifo_empty;
    logic       ovr_evt;

    uart_tx_fifo #(.AW(FIFO_AW), .W(8)) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .wr_en   (tx_fifo_wr_en),
        .wr_data (tx_fifo_wr_data),
        .rd_en   (pop),
        .rd_data (fifo_dat),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .level   (tx_fifo_level)
    );

    // >= so a lowered divisor never waits for a full 8-bit wrap
    assign tick    = (tick_cnt >= baud_16x_in_cycles);
    assign bit_end = tick & (sub_cnt == ((state == ST_STOP) ? LAST_TICK_STOP : LAST_TICK_BIT));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tick_cnt <= '0;
        end else if (pop || tick) begin
            tick_cnt <= '0;
        end else begin
            tick_cnt <= tick_cnt + 8'd1;
        end
    end

    always_comb begin
        state_nxt   = state;
        sub_cnt_nxt = sub_cnt;
        bit_idx_nxt = bit_idx;
        shift_nxt   = shift;
        pop         = 1'b0;
        if (state != ST_IDLE && tick) begin
            sub_cnt_nxt = bit_end ? 5'd0 : sub_cnt + 5'd1;
        end
        case (state)
            ST_IDLE: begin
                if (!fifo_empty) begin
                    pop         = 1'b1;
                    shift_nxt   = fifo_dat;
                    sub_cnt_nxt = 5'd0;
                    state_nxt   = ST_START;
                end
            end
            ST_START: begin
                if (bit_end) begin
                    bit_idx_nxt = 3'd0;
                    state_nxt   = ST_DATA;
                end
            end
            ST_DATA: begin
                if (bit_end) begin
                    if (bit_idx == LAST_DATA_BIT) begin
                        state_nxt = ST_STOP;
                    end else begin
                        bit_idx_nxt = bit_idx + 3'd1;
                        shift_nxt   = {1'b0, shift[7:1]};
                    end
                end
            end
            default: begin
                if (bit_end) begin
                    if (!fifo_empty) begin
                        pop       = 1'b1;
                        shift_nxt = fifo_dat;
                        state_nxt = ST_START;
                    end else begin
                        state_nxt = ST_IDLE;
                    end
                end
            end
        endcase
        case (state_nxt)
            ST_START: txd_nxt = 1'b0;
            ST_DATA:  txd_nxt = shift_nxt[0];
            default:  txd_nxt = 1'b1;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= ST_IDLE;
            sub_cnt  <= '0;
            bit_idx  <= '0;
            shift    <= '0;
            uart_txd <= 1'b1;
        end else begin
            state    <= state_nxt;
            sub_cnt  <= sub_cnt_nxt;
            bit_idx  <= bit_idx_nxt;
            shift    <= shift_nxt;
            uart_txd <= txd_nxt;
        end
    end

    // a pop in the same cycle frees a slot, so only a truly blocked push counts
    assign ovr_evt = tx_fifo_wr_en & fifo_full & ~pop;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tx_fifo_overrun <= 1'b0;
        end else if (ovr_evt) begin
            tx_fifo_overrun <= 1'b1;
        end else if (tx_overrun_clr) begin
            tx_fifo_overrun <= 1'b0;
        end
    end

    assign tx_fifo_rdy = ~fifo_full;
    assign tx_busy     = (state != ST_IDLE) | ~fifo_empty;

endmodule

// File: tb/tb_uart_tx.sv
// Bench for uart_tx: one instance per stop-bit setting, both driven identically and checked
// every cycle against a frame-arithmetic model, plus directed literal checks.
module tb_uart_tx;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       wr_en, clr;
    logic [7:0] wr_data, div;
    logic [1:0] rdy, ovr, busy, txd;
    logic [4:0] lvl0, lvl1;

    always #5 clk = ~clk;

    uart_tx #(.FIFO_AW(4), .STOP_BITS(1)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .tx_fifo_wr_en(wr_en), .tx_fifo_wr_data(wr_data),
        .baud_16x_in_cycles(div), .tx_overrun_clr(clr), .tx_fifo_rdy(rdy[0]),
        .tx_fifo_overrun(ovr[0]), .tx_fifo_level(lvl0), .tx_busy(busy[0]), .uart_txd(txd[0])
    );

    uart_tx #(.FIFO_AW(4), .STOP_BITS(2)) u_dut2 (
        .clk(clk), .rst_n(rst_n), .tx_fifo_wr_en(wr_en), .tx_fifo_wr_data(wr_data),
        .baud_16x_in_cycles(div), .tx_overrun_clr(clr), .tx_fifo_rdy(rdy[1]),
        .tx_fifo_overrun(ovr[1]), .tx_fifo_level(lvl1), .tx_busy(busy[1]), .uart_txd(txd[1])
    );

    int tests = 0;
    int fails = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Model: FIFO as a shifting array; a frame is described only by its start edge and byte.
    logic [7:0] mq [2][16];
    int         mcnt [2];
    bit         mact [2];
    longint     ms [2];
    logic [7:0] mbyte [2];
    bit         mov [2];
    longint     ecnt;
    int         m_pre, m_blen;
    bit         m_pop, m_evt;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ecnt = 0;
            for (int i = 0; i < 2; i++) begin
                mcnt[i] = 0; mact[i] = 0; mov[i] = 0; ms[i] = 0;
            end
        end else begin
            ecnt++;
            for (int i = 0; i < 2; i++) begin
                m_pre  = mcnt[i];
                m_blen = 16 * (int'(div) + 1);
                m_pop  = 0;
                m_evt  = 0;
                if (mact[i] && (ecnt - ms[i] == longint'((10 + i) * m_blen))) begin
                    if (m_pre > 0) m_pop = 1;
                    else mact[i] = 0;
                end else if (!mact[i] && m_pre > 0) begin
                    m_pop = 1;
                end
                if (m_pop) begin
                    mbyte[i] = mq[i][0];
                    for (int j = 0; j < 15; j++) mq[i][j] = mq[i][j+1];
                    mcnt[i]--;
                    mact[i] = 1;
                    ms[i]   = ecnt;
                end
                if (wr_en) begin
                    if (m_pre < 16 || m_pop) begin
                        mq[i][mcnt[i]] = wr_data;
                        mcnt[i]++;
                    end else begin
                        m_evt = 1;
                    end
                end
                if (m_evt) mov[i] = 1;
                else if (clr) mov[i] = 0;
            end
        end
    end

    function automatic logic exp_txd(input int i);
        longint k;
        int b;
        if (!mact[i]) return 1'b1;
        k = ecnt - ms[i];
        b = int'(k / longint'(16 * (int'(div) + 1)));
        if (b == 0) return 1'b0;
        if (b <= 8) return mbyte[i][b-1];
        return 1'b1;
    endfunction

    always @(negedge clk) begin
        if (rst_n) begin
            for (int i = 0; i < 2; i++) begin
                check(i == 0 ? "d1.txd" : "d2.txd", txd[i], exp_txd(i));
                check(i == 0 ? "d1.level" : "d2.level", (i == 0) ? lvl0 : lvl1, mcnt[i]);
                check(i == 0 ? "d1.rdy" : "d2.rdy", rdy[i], mcnt[i] < 16);
                check(i == 0 ? "d1.overrun" : "d2.overrun", ovr[i], mov[i]);
                check(i == 0 ? "d1.busy" : "d2.busy", busy[i], mact[i] || mcnt[i] > 0);
            end
        end
    end

    task automatic step();
        @(negedge clk);
    endtask

    task automatic push(input logic [7:0] d);
        wr_en = 1'b1; wr_data = d;
        step();
        wr_en = 1'b0;
    endtask

    task automatic wait_idle(input int limit);
        int n = 0;
        while (busy != 2'b00 && n < limit) begin
            step();
            n++;
        end
        check("idle_wait", busy, 0);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        step();
        step();
        rst_n = 1'b1;
    endtask

    initial begin
        logic [9:0] seq;
        int lows;
        wr_en = 0; wr_data = 0; clr = 0; div = 8'd2;
        repeat (3) step();
        check("rst.level", lvl0, 0);
        check("rst.rdy", rdy, 2'b11);
        check("rst.overrun", ovr, 0);
        check("rst.busy", busy, 0);
        check("rst.txd", txd, 2'b11);
        rst_n = 1'b1;
        step();

        // divisor 2, 0xA5: each level 48 clocks, 480-clock frame
        seq = {1'b1, 8'hA5, 1'b0};
        push(8'hA5);
        check("s1.pre_start_txd", txd[0], 1);
        check("s1.level", lvl0, 1);
        step();
        for (int k = 0; k <= 480; k++) begin
            if (k < 480 && (k % 48 == 0 || k % 48 == 47)) check("s1.bit", txd[0], seq[k/48]);
            if (k == 479) check("s1.busy_end", busy[0], 1);
            if (k == 480) check("s1.idle", busy[0], 0);
            if (k < 480) step();
        end
        wait_idle(1000);

        // divisor 0, 0x00 then 0xFF back-to-back: no gap between frames
        div = 8'd0;
        step();
        wr_en = 1; wr_data = 8'h00; step();
        wr_data = 8'hFF; step();
        wr_en = 0;
        check("s2.start", txd[0], 0);
        check("s2.level", lvl0, 1);
        for (int k = 0; k <= 320; k++) begin
            if (k == 80)  check("s2.data0", txd[0], 0);
            if (k == 159) check("s2.stop", txd[0], 1);
            if (k == 160) check("s2.start2", txd[0], 0);
            if (k == 240) check("s2.data1", txd[0], 1);
            if (k == 319) check("s2.busy_end", busy[0], 1);
            if (k == 320) check("s2.idle", busy[0], 0);
            if (k < 320) step();
        end
        wait_idle(1000);

        // slow divisor: fill to 16, overrun, set-wins, clear
        div = 8'd255;
        step();
        wr_en = 1;
        for (int k = 0; k < 17; k++) begin
            wr_data = 8'($urandom);
            step();
        end
        wr_en = 0;
        check("s3.level", lvl0, 16);
        check("s3.rdy", rdy, 2'b00);
        check("s3.no_ovr", ovr, 0);
        push(8'h5A);
        check("s3.ovr", ovr, 2'b11);
        check("s3.level_held", lvl1, 16);
        wr_en = 1; clr = 1; step();
        wr_en = 0;
        check("s3.set_wins", ovr, 2'b11);
        step();
        clr = 0;
        check("s3.cleared", ovr, 0);
        do_reset();
        check("s3.rst_level", lvl0, 0);

        // divisor 0: push into a full FIFO exactly on the pop edge
        div = 8'd0;
        step();
        wr_en = 1;
        for (int k = 0; k < 17; k++) begin
            wr_data = 8'($urandom);
            step();
        end
        wr_en = 0;
        repeat (144) step();
        check("s4.full_before", lvl0, 16);
        push(8'hC3);
        check("s4.level", lvl0, 16);
        check("s4.no_ovr", ovr[0], 0);
        check("s4.restart", txd[0], 0);
        check("s4.d2_ovr", ovr[1], 1);
        do_reset();

        // reset during data bit 3 of 0x3C
        div = 8'd0;
        step();
        push(8'h3C);
        step();
        repeat (70) step();
        check("s5.bit3", txd[0], 1);
        check("s5.busy", busy[0], 1);
        #2 rst_n = 1'b0;
        #1;
        check("s5.txd_async", txd, 2'b11);
        check("s5.level", lvl0, 0);
        check("s5.busy_rst", busy, 0);
        step();
        step();
        rst_n = 1'b1;
        lows = 0;
        for (int k = 0; k < 200; k++) begin
            step();
            if (txd != 2'b11 || busy != 2'b00) lows++;
        end
        check("s5.no_spurious", lows, 0);

        // two stop bits, divisor 1, 0x55: 352-clock frame on d2
        div = 8'd1;
        step();
        push(8'h55);
        step();
        for (int k = 0; k <= 352; k++) begin
            if (k == 31)  check("s6.start", txd[1], 0);
            if (k == 32)  check("s6.bit0", txd[1], 1);
            if (k == 287) check("s6.bit7", txd[1], 0);
            if (k == 288) check("s6.stop", txd[1], 1);
            if (k == 320) check("s6.d1_idle", busy[0], 0);
            if (k == 351) check("s6.busy_end", busy[1], 1);
            if (k == 352) check("s6.idle", busy[1], 0);
            if (k < 352) step();
        end

        // randomised traffic; divisor only changes while idle
        for (int r = 0; r < 4; r++) begin
            div = 8'($urandom_range(0, 2));
            step();
            for (int n = 0; n < 600; n++) begin
                wr_en   = ($urandom_range(0, 3) == 0);
                wr_data = 8'($urandom);
                clr     = ($urandom_range(0, 15) == 0);
                step();
            end
            wr_en = 0;
            clr   = 0;
            wait_idle(12000);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached, tests=%0d failed=%0d", tests, fails);
        $fatal(1, "watchdog");
    end

endmodule
